// File: rtl/dmem_lsu.sv
// Load/store initiator driving a byte-enabled, 1-cycle-latency synchronous data memory port.
// Define DMEM_LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats; otherwise they are rejected with resp_err.
module dmem_lsu #(
   parameter int AWIDTH = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              dmem_en,
   output logic [3:0]        dmem_we,
   output logic [AWIDTH-1:0] dmem_addr,
   output logic [31:0]       dmem_din,
   input  logic [31:0]       dmem_dout
);

`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
   localparam bit SplitEn = 1'b1;
`else
   localparam bit SplitEn = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT2 = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t              state_q;
   logic                we_q;
   logic                uns_q;
   logic [1:0]          size_q;
   logic [1:0]          off_q;
   logic [AWIDTH-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic                split_q;
   logic [3:0]          hi_we_q;
   logic                err_q;
   logic [31:0]         low_q;

   logic [1:0]          off_in;
   logic [7:0]          mask8_in;
   logic                split_in;
   logic                accept;
   logic [5:0]          hi_shift;
   logic [63:0]         rd_cat;
   logic [31:0]         rd_word;
   logic [31:0]         rd_ext;
   logic                unused_addr_hi;

   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         2'd0:    return 4'b0001;
         2'd1:    return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   assign off_in         = req_addr[1:0];
   assign mask8_in       = {4'b0000, size_mask(req_size)} << off_in;
   assign split_in       = |mask8_in[7:4];
   assign req_ready      = (state_q == IDLE);
   assign accept         = req_valid && req_ready && !rst;
   assign unused_addr_hi = ^req_addr[31:AWIDTH+2];

   // Upper-word lanes of a split store come from the top of the right-aligned data.
   assign hi_shift = 6'd32 - {1'b0, off_q, 3'b000};

   always_comb begin
      dmem_en   = 1'b0;
      dmem_we   = 4'b0000;
      dmem_addr = '0;
      dmem_din  = 32'h0;
      case (state_q)
         IDLE: begin
            if (accept && (SplitEn || !split_in)) begin
               dmem_en   = 1'b1;
               dmem_addr = req_addr[AWIDTH+1:2];
               dmem_we   = req_we ? mask8_in[3:0] : 4'b0000;
               dmem_din  = req_wdata << {off_in, 3'b000};
            end
         end
         BEAT2: begin
            dmem_en   = 1'b1;
            dmem_addr = addr_q + {{(AWIDTH-1){1'b0}}, 1'b1};
            dmem_we   = we_q ? hi_we_q : 4'b0000;
            dmem_din  = wdata_q >> hi_shift;
         end
         default: ;
      endcase
   end

   // Memory output is held through RESP because nothing is enabled there.
   always_comb begin
      rd_cat  = split_q ? {dmem_dout, low_q} : {32'h0, dmem_dout};
      rd_word = 32'(rd_cat >> {off_q, 3'b000});
      case (size_q)
         2'd0:    rd_ext = {{24{~uns_q & rd_word[7]}}, rd_word[7:0]};
         2'd1:    rd_ext = {{16{~uns_q & rd_word[15]}}, rd_word[15:0]};
         default: rd_ext = rd_word;
      endcase
   end

   assign resp_valid = (state_q == RESP);
   assign resp_err   = (state_q == RESP) && err_q;
   assign resp_rdata = ((state_q == RESP) && !we_q && !err_q) ? rd_ext : 32'h0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'd0;
         off_q   <= 2'd0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         split_q <= 1'b0;
         hi_we_q <= 4'b0000;
         err_q   <= 1'b0;
         low_q   <= 32'h0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  uns_q   <= req_unsigned;
                  size_q  <= req_size;
                  off_q   <= off_in;
                  addr_q  <= req_addr[AWIDTH+1:2];
                  wdata_q <= req_wdata;
                  split_q <= split_in;
                  hi_we_q <= mask8_in[7:4];
                  if (split_in && !SplitEn) begin
                     err_q   <= 1'b1;
                     state_q <= RESP;
                  end else begin
                     err_q   <= 1'b0;
                     state_q <= split_in ? BEAT2 : RESP;
                  end
               end
            end
            BEAT2: begin
               low_q   <= dmem_dout;
               state_q <= RESP;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: byte-level reference memory, per-cycle port checker, directed and random requests.
module tb_dmem_lsu;
   localparam int AW    = 14;
   localparam int WORDS = 1 << AW;
`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic          clk, rst;
   logic          req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]    req_size;
   logic [31:0]   req_addr, req_wdata;
   logic          resp_valid, resp_err;
   logic [31:0]   resp_rdata;
   logic          dmem_en;
   logic [3:0]    dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [31:0]   dmem_din, dmem_dout;

   dmem_lsu #(.AWIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .dmem_en(dmem_en), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_dout(dmem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pat(input int i);
      return (i * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // Memory attached to the DUT
   logic [31:0] ram [WORDS];
   bit ram_init_done = 1'b0;
   always @(posedge clk) begin
      if (!ram_init_done) begin
         for (int i = 0; i < WORDS; i++) ram[i] <= pat(i);
         ram_init_done <= 1'b1;
      end else if (dmem_en) begin
         for (int l = 0; l < 4; l++)
            if (dmem_we[l]) ram[dmem_addr][8*l +: 8] <= dmem_din[8*l +: 8];
         dmem_dout <= ram[dmem_addr];
      end
   end

   // Reference model: byte-addressed memory and a queue of expected per-cycle port values
   typedef struct {
      logic          en;
      logic [3:0]    we;
      logic [AW-1:0] addr;
      logic [31:0]   din;
      logic [31:0]   dmask;
      logic          rv;
      logic [31:0]   rdata;
      logic          err;
      logic          rdy;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] rmem [WORDS];

   function automatic exp_t idle_exp();
      exp_t e;
      e.en = 1'b0; e.we = 4'h0; e.addr = '0; e.din = 32'h0; e.dmask = 32'h0;
      e.rv = 1'b0; e.rdata = 32'h0; e.err = 1'b0; e.rdy = 1'b1;
      return e;
   endfunction

   initial begin : monitor
      exp_t          cur, rsp;
      exp_t          bt [2];
      int            n, pos, lane, k;
      logic [1:0]    off;
      logic [AW-1:0] wa, wa1, w;
      logic [31:0]   ld;
      bit            is_split;
      for (int i = 0; i < WORDS; i++) rmem[i] = pat(i);
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_ready", {31'h0, req_ready}, 32'h1);
            chk("rst_en", {31'h0, dmem_en}, 32'h0);
            chk("rst_we", {28'h0, dmem_we}, 32'h0);
            chk("rst_addr", 32'(dmem_addr), 32'h0);
            chk("rst_din", dmem_din, 32'h0);
            chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
            chk("rst_rdata", resp_rdata, 32'h0);
            chk("rst_err", {31'h0, resp_err}, 32'h0);
            exp_q.delete();
         end else begin
            if (exp_q.size() != 0) begin
               cur = exp_q.pop_front();
            end else if (req_valid) begin
               n        = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
               off      = req_addr[1:0];
               wa       = req_addr[AW+1:2];
               wa1      = wa + 1'b1;
               is_split = (int'(off) + n) > 4;
               rsp      = idle_exp();
               rsp.rdy  = 1'b0;
               rsp.rv   = 1'b1;
               if (is_split && !SPLIT) begin
                  cur     = idle_exp();
                  rsp.err = 1'b1;
                  exp_q.push_back(rsp);
               end else begin
                  bt[0] = idle_exp(); bt[0].en = 1'b1; bt[0].addr = wa;
                  bt[1] = idle_exp(); bt[1].en = 1'b1; bt[1].addr = wa1; bt[1].rdy = 1'b0;
                  ld = 32'h0;
                  for (int i = 0; i < n; i++) begin
                     pos  = int'(off) + i;
                     lane = pos % 4;
                     k    = pos / 4;
                     w    = (k != 0) ? wa1 : wa;
                     if (req_we) begin
                        bt[k].we[lane]           = 1'b1;
                        bt[k].din[8*lane +: 8]   = req_wdata[8*i +: 8];
                        bt[k].dmask[8*lane +: 8] = 8'hFF;
                     end
                     ld = ld | (32'(rmem[w][8*lane +: 8]) << (8*i));
                  end
                  if (!req_unsigned && n < 4 && ld[8*n-1]) ld = ld | (32'hFFFFFFFF << (8*n));
                  rsp.rdata = req_we ? 32'h0 : ld;
                  cur = bt[0];
                  if (is_split) exp_q.push_back(bt[1]);
                  exp_q.push_back(rsp);
               end
            end else begin
               cur = idle_exp();
            end
            chk("ready", {31'h0, req_ready}, {31'h0, cur.rdy});
            chk("dmem_en", {31'h0, dmem_en}, {31'h0, cur.en});
            chk("dmem_we", {28'h0, dmem_we}, {28'h0, cur.we});
            if (cur.en) chk("dmem_addr", 32'(dmem_addr), 32'(cur.addr));
            if (cur.we != 4'h0) chk("dmem_din", dmem_din & cur.dmask, cur.din);
            chk("resp_valid", {31'h0, resp_valid}, {31'h0, cur.rv});
            if (cur.rv) begin
               chk("resp_rdata", resp_rdata, cur.rdata);
               chk("resp_err", {31'h0, resp_err}, {31'h0, cur.err});
            end
            if (cur.en)
               for (int l = 0; l < 4; l++)
                  if (cur.we[l]) rmem[cur.addr][8*l +: 8] = cur.din[8*l +: 8];
         end
      end
   end

   // Driver with capture of beats and response for literal checks
   logic          cap_en1, cap_en2, cap_err;
   logic [3:0]    cap_we1, cap_we2;
   logic [AW-1:0] cap_addr1, cap_addr2;
   logic [31:0]   cap_din1, cap_din2, cap_rdata;
   int            cap_lat;

   task automatic do_req(input logic we, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd, input bit noise);
      bit got;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = un;
      req_addr = a; req_wdata = wd;
      @(negedge clk);
      cap_en1 = dmem_en; cap_we1 = dmem_we; cap_addr1 = dmem_addr; cap_din1 = dmem_din;
      cap_en2 = 1'b0; cap_we2 = 4'h0; cap_addr2 = '0; cap_din2 = 32'h0;
      cap_rdata = 32'h0; cap_err = 1'b0; cap_lat = 0; got = 1'b0;
      for (int c = 1; c <= 6 && !got; c++) begin
         @(posedge clk); #1;
         if (noise) begin
            req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
            req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
         if (c == 1) begin
            cap_en2 = dmem_en; cap_we2 = dmem_we; cap_addr2 = dmem_addr; cap_din2 = dmem_din;
         end
         if (resp_valid) begin
            got = 1'b1; cap_lat = c; cap_rdata = resp_rdata; cap_err = resp_err;
         end
      end
      req_valid = 1'b0;
      if (!got) begin
         errors++; checks++;
         $display("FAIL resp_timeout: got no resp_valid expected one within 6 cycles, addr %08h", a);
      end
      $display("txn we=%0d size=%0d uns=%0d addr=%08h wdata=%08h -> lat=%0d rdata=%08h err=%0d",
               we, sz, un, a, wd, cap_lat, cap_rdata, cap_err);
   endtask

   initial begin : driver
      logic [AW-1:0] wsel;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
      chk("sw_we", {28'h0, cap_we1}, 32'hF);
      chk("sw_addr", 32'(cap_addr1), 32'h4);
      chk("sw_din", cap_din1, 32'hDEADBEEF);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
      chk("lw_rdata", cap_rdata, 32'hDEADBEEF);
      chk("lw_lat", 32'(cap_lat), 32'd1);

      do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, 1'b0);
      chk("sb_we", {28'h0, cap_we1}, 32'h8);
      chk("sb_din_hi", {24'h0, cap_din1[31:24]}, 32'h80);
      do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0);
      chk("lb_signed", cap_rdata, 32'hFFFFFF80);
      do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0);
      chk("lbu_unsigned", cap_rdata, 32'h00000080);

      do_req(1'b1, 2'd1, 1'b0, 32'h41, 32'h0000BEEF, 1'b0);
      chk("sh_off1_we", {28'h0, cap_we1}, 32'h6);
      do_req(1'b0, 2'd1, 1'b1, 32'h41, 32'h0, 1'b0);
      chk("lhu_off1", cap_rdata, 32'h0000BEEF);
      chk("lhu_off1_err", {31'h0, cap_err}, 32'h0);

      if (SPLIT) begin
         do_req(1'b1, 2'd2, 1'b0, 32'h22, 32'h11223344, 1'b0);
         chk("split_we1", {28'h0, cap_we1}, 32'hC);
         chk("split_addr1", 32'(cap_addr1), 32'h8);
         chk("split_din1", {16'h0, cap_din1[31:16]}, 32'h3344);
         chk("split_we2", {28'h0, cap_we2}, 32'h3);
         chk("split_addr2", 32'(cap_addr2), 32'h9);
         chk("split_din2", {16'h0, cap_din2[15:0]}, 32'h1122);
         chk("split_lat", 32'(cap_lat), 32'd2);
         do_req(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1'b0);
         chk("split_load", cap_rdata, 32'h11223344);

         do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h000000A5, 1'b0);
         do_req(1'b1, 2'd2, 1'b0, 32'(4*(WORDS-1)), 32'h7F000000, 1'b0);
         do_req(1'b0, 2'd1, 1'b0, 32'(4*(WORDS-1)+3), 32'h0, 1'b0);
         chk("wrap_addr2", 32'(cap_addr2), 32'h0);
         chk("wrap_rdata", cap_rdata, 32'hFFFFA57F);
      end else begin
         do_req(1'b0, 2'd2, 1'b0, 32'h21, 32'h0, 1'b0);
         chk("mis_en1", {31'h0, cap_en1}, 32'h0);
         chk("mis_en2", {31'h0, cap_en2}, 32'h0);
         chk("mis_err", {31'h0, cap_err}, 32'h1);
         chk("mis_rdata", cap_rdata, 32'h0);
         chk("mis_lat", 32'(cap_lat), 32'd1);
      end

      // Reset in the cycle after accepting a split store
      do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h0, 1'b0);
      do_req(1'b1, 2'd2, 1'b0, 32'h34, 32'h0, 1'b0);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h32; req_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      req_valid = 1'b0; rst = 1'b1;
      #1;
      chk("rst_mid_en", {31'h0, dmem_en}, 32'h0);
      chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_mid_resp", {31'h0, resp_valid}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("rst_rel_ready", {31'h0, req_ready}, 32'h1);
      $display("txn reset asserted during split store at 00000032");
      repeat (3) @(posedge clk);
      do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b0);
      chk("rst_partial_lo", cap_rdata, SPLIT ? 32'hF00D0000 : 32'h0);
      do_req(1'b0, 2'd2, 1'b0, 32'h34, 32'h0, 1'b0);
      chk("rst_partial_hi", cap_rdata, 32'h0);

      for (int t = 0; t < 300; t++) begin
         case ($urandom_range(0, 9))
            8:       wsel = AW'(WORDS - 1);
            9:       wsel = AW'(WORDS - 2);
            default: wsel = AW'($urandom_range(0, 7));
         endcase
         do_req(1'($urandom), 2'($urandom), 1'($urandom),
                {($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h0, wsel, 2'($urandom)},
                $urandom, 1'b1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
